// File: rtl/run_monitor.sv
// Run controller and execution tracer for the rv32i core.
// Gates core run enable, counts cycles, halts, and keeps a circular trace.
module run_monitor #(
    parameter int unsigned PC_W        = 16,
    parameter int unsigned INSTR_W     = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MAX_CYCLES  = 64,
    parameter int unsigned TRACE_DEPTH = 16,
    parameter logic [INSTR_W-1:0] HALT_INSTR = 32'h00100073
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [PC_W-1:0]                pc,
    input  logic [INSTR_W-1:0]             instr,
    input  logic                           instr_valid,
    input  logic [DATA_W-1:0]              mem_out,
    output logic                           core_en,
    output logic                           halted,
    output logic [1:0]                     halt_cause,
    output logic [31:0]                    cycle_count,
    output logic [$clog2(TRACE_DEPTH):0]   trace_count,
    input  logic [$clog2(TRACE_DEPTH)-1:0] rd_idx,
    output logic [PC_W-1:0]                rd_pc,
    output logic [INSTR_W-1:0]             rd_instr,
    output logic [DATA_W-1:0]              rd_data
);

    localparam int unsigned AW = $clog2(TRACE_DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    localparam logic [1:0] C_NONE   = 2'b00;
    localparam logic [1:0] C_INVAL  = 2'b01;
    localparam logic [1:0] C_EBREAK = 2'b10;
    localparam logic [1:0] C_BUDGET = 2'b11;

    // With MAX_CYCLES=0 this wraps to all-ones but is masked off below.
    localparam logic [31:0] LAST_CYC = 32'(MAX_CYCLES - 1);
    localparam logic [CW-1:0] FULL   = CW'(TRACE_DEPTH);

    logic [1:0]    state_q, state_d;
    logic [1:0]    cause_q, cause_d;
    logic [31:0]   cyc_q, cyc_d;
    logic [CW-1:0] tcnt_q, tcnt_d;
    logic [AW-1:0] wptr_q, wptr_d;

    logic [PC_W-1:0]    rd_pc_q, rd_pc_d;
    logic [INSTR_W-1:0] rd_instr_q, rd_instr_d;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;

    logic [PC_W-1:0]    ram_pc    [TRACE_DEPTH];
    logic [INSTR_W-1:0] ram_instr [TRACE_DEPTH];
    logic [DATA_W-1:0]  ram_data  [TRACE_DEPTH];

    logic          in_run;
    logic          budget_hit;
    logic [1:0]    new_cause;
    logic          halt_now;
    logic          trace_we;
    logic [AW-1:0] rd_addr;

    // Halt detection in priority order; only meaningful while running.
    always_comb begin
        in_run     = (state_q == S_RUN);
        budget_hit = (MAX_CYCLES != 0) && (cyc_q == LAST_CYC);
        new_cause  = C_NONE;
        if (!instr_valid) begin
            new_cause = C_INVAL;
        end else if (instr == HALT_INSTR) begin
            new_cause = C_EBREAK;
        end else if (budget_hit) begin
            new_cause = C_BUDGET;
        end
        halt_now = in_run && (new_cause != C_NONE);
        // ebreak and budget cycles still retire; an invalid fetch does not.
        trace_we = in_run && instr_valid;
        rd_addr  = wptr_q - tcnt_q[AW-1:0] + rd_idx;
    end

    // Next-state and counter update for the IDLE/RUN/HALT controller.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        cyc_d   = cyc_q;
        tcnt_d  = tcnt_q;
        wptr_d  = wptr_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d = S_RUN;
                    cause_d = C_NONE;
                    cyc_d   = '0;
                    tcnt_d  = '0;
                    wptr_d  = '0;
                end
            end
            S_RUN: begin
                if (trace_we) begin
                    wptr_d = wptr_q + AW'(1);
                    cyc_d  = cyc_q + 32'd1;
                    if (tcnt_q != FULL) begin
                        tcnt_d = tcnt_q + CW'(1);
                    end
                end
                if (halt_now) begin
                    state_d = S_HALT;
                    cause_d = new_cause;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Registered trace readout, addressed relative to the oldest entry.
    always_comb begin
        rd_pc_d    = ram_pc[rd_addr];
        rd_instr_d = ram_instr[rd_addr];
        rd_data_d  = ram_data[rd_addr];
    end

    // Controller state, counters and read registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cause_q    <= C_NONE;
            cyc_q      <= '0;
            tcnt_q     <= '0;
            wptr_q     <= '0;
            rd_pc_q    <= '0;
            rd_instr_q <= '0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cause_q    <= cause_d;
            cyc_q      <= cyc_d;
            tcnt_q     <= tcnt_d;
            wptr_q     <= wptr_d;
            rd_pc_q    <= rd_pc_d;
            rd_instr_q <= rd_instr_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Trace RAM; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (trace_we) begin
            ram_pc[wptr_q]    <= pc;
            ram_instr[wptr_q] <= instr;
            ram_data[wptr_q]  <= mem_out;
        end
    end

    // Enable drops combinationally on a halt so the core never advances.
    assign core_en     = in_run && !halt_now;
    assign halted      = (state_q == S_HALT);
    assign halt_cause  = cause_q;
    assign cycle_count = cyc_q;
    assign trace_count = tcnt_q;
    assign rd_pc       = rd_pc_q;
    assign rd_instr    = rd_instr_q;
    assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_run_monitor.sv
// Bench for run_monitor: one budgeted and one unlimited instance,
// a cycle model of the run, and a scoreboard for trace readback.
module tb_run_monitor;

    localparam logic [31:0] HALT_W = 32'h00100073;
    localparam int DEPTH = 16;

    typedef struct packed {
        logic [15:0] pc;
        logic [31:0] ins;
        logic [31:0] dat;
    } tr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic [15:0] pc = '0;
    logic [31:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic [31:0] mem_out = '0;
    logic [3:0]  rd_idx = '0;

    logic        core_en_a, core_en_b;
    logic        halted_a, halted_b;
    logic [1:0]  cause_a, cause_b;
    logic [31:0] cyc_a, cyc_b;
    logic [4:0]  tc_a, tc_b;
    logic [15:0] rpc_a, rpc_b;
    logic [31:0] rins_a, rins_b;
    logic [31:0] rdat_a, rdat_b;

    bit sel = 1'b0;
    logic        o_en, o_halted;
    logic [1:0]  o_cause;
    logic [31:0] o_cyc;
    logic [4:0]  o_tc;
    logic [15:0] o_rpc;
    logic [31:0] o_rins, o_rdat;

    assign o_en     = sel ? core_en_b : core_en_a;
    assign o_halted = sel ? halted_b : halted_a;
    assign o_cause  = sel ? cause_b : cause_a;
    assign o_cyc    = sel ? cyc_b : cyc_a;
    assign o_tc     = sel ? tc_b : tc_a;
    assign o_rpc    = sel ? rpc_b : rpc_a;
    assign o_rins   = sel ? rins_b : rins_a;
    assign o_rdat   = sel ? rdat_b : rdat_a;

    tr_t  m_trace[$];
    tr_t  sb_q[$];
    int   m_cyc;
    int   n_err = 0;
    int   n_chk = 0;

    always #5 clk = ~clk;

    run_monitor #(.MAX_CYCLES(64), .TRACE_DEPTH(16)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a),
        .pc(pc), .instr(instr), .instr_valid(instr_valid),
        .mem_out(mem_out), .core_en(core_en_a),
        .halted(halted_a), .halt_cause(cause_a),
        .cycle_count(cyc_a), .trace_count(tc_a),
        .rd_idx(rd_idx), .rd_pc(rpc_a),
        .rd_instr(rins_a), .rd_data(rdat_a)
    );

    run_monitor #(.MAX_CYCLES(0), .TRACE_DEPTH(16)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b),
        .pc(pc), .instr(instr), .instr_valid(instr_valid),
        .mem_out(mem_out), .core_en(core_en_b),
        .halted(halted_b), .halt_cause(cause_b),
        .cycle_count(cyc_b), .trace_count(tc_b),
        .rd_idx(rd_idx), .rd_pc(rpc_b),
        .rd_instr(rins_b), .rd_data(rdat_b)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] gen_ins(input int k);
        return (32'(k) << 16) | 32'h0000_0013;
    endfunction

    function automatic logic [31:0] gen_dat(input int k);
        return 32'hA5A5_0000 ^ 32'(k * 3);
    endfunction

    task automatic pulse_start();
        @(posedge clk); #1;
        if (sel) start_b = 1'b1;
        else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_en"}, 32'(o_en), 32'd0);
        chk({tag, "_halted"}, 32'(o_halted), 32'd0);
        chk({tag, "_cause"}, 32'(o_cause), 32'd0);
        chk({tag, "_cyc"}, o_cyc, 32'd0);
        chk({tag, "_tc"}, 32'(o_tc), 32'd0);
        chk({tag, "_rpc"}, 32'(o_rpc), 32'd0);
        chk({tag, "_rins"}, o_rins, 32'd0);
    endtask

    task automatic run_prog(input int n_valid, input int brk_at,
                            input int rst_at, input int sp_at);
        int max_c;
        logic [1:0] c;
        logic [1:0] m_cause;
        bit done;
        max_c = sel ? 0 : 64;
        m_trace.delete();
        m_cyc = 0;
        m_cause = 2'b00;
        done = 1'b0;
        pulse_start();
        for (int k = 0; k < 2000 && !done; k++) begin
            pc = 16'(k * 4);
            instr = (k == brk_at) ? HALT_W : gen_ins(k);
            instr_valid = (k < n_valid);
            mem_out = gen_dat(k);
            if (k == sp_at) begin
                if (sel) start_b = 1'b1;
                else start_a = 1'b1;
            end
            if (!instr_valid) c = 2'b01;
            else if (instr == HALT_W) c = 2'b10;
            else if (max_c != 0 && m_cyc == max_c - 1) c = 2'b11;
            else c = 2'b00;
            @(negedge clk);
            if (k == 0) begin
                chk("run0_cyc", o_cyc, 32'd0);
                chk("run0_tc", 32'(o_tc), 32'd0);
                chk("run0_cause", 32'(o_cause), 32'd0);
                chk("run0_halted", 32'(o_halted), 32'd0);
            end
            chk("core_en", 32'(o_en), 32'(c == 2'b00));
            if (k == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk_reset_vals("midrst");
                @(posedge clk); #1;
                rst_n = 1'b1;
                start_a = 1'b0;
                start_b = 1'b0;
                return;
            end
            if (c != 2'b01) begin
                m_trace.push_back(tr_t'{pc, instr, mem_out});
                if (m_trace.size() > DEPTH) void'(m_trace.pop_front());
                m_cyc++;
            end
            if (c != 2'b00) begin
                m_cause = c;
                done = 1'b1;
            end
            @(posedge clk); #1;
            start_a = 1'b0;
            start_b = 1'b0;
        end
        if (!done) chk("run_timeout", 32'd0, 32'd1);
        @(negedge clk);
        chk("halted", 32'(o_halted), 32'd1);
        chk("halt_en", 32'(o_en), 32'd0);
        chk("cause", 32'(o_cause), 32'(m_cause));
        chk("cycle_count", o_cyc, 32'(m_cyc));
        chk("trace_count", 32'(o_tc), 32'(m_trace.size()));
    endtask

    task automatic read_chk(input int idx);
        tr_t e;
        if (idx >= m_trace.size()) begin
            chk("rd_range", 32'(idx), 32'(m_trace.size()));
            return;
        end
        rd_idx = 4'(idx);
        sb_q.push_back(m_trace[idx]);
        @(posedge clk);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
            return;
        end
        e = sb_q.pop_front();
        chk("rd_pc", 32'(o_rpc), 32'(e.pc));
        chk("rd_instr", o_rins, e.ins);
        chk("rd_data", o_rdat, e.dat);
    endtask

    initial begin
        #23;
        sel = 1'b0;
        chk_reset_vals("rst_a");
        sel = 1'b1;
        chk_reset_vals("rst_b");
        rst_n = 1'b1;

        // five valid words, then off the end of the program
        sel = 1'b0;
        run_prog(5, -1, -1, -1);
        for (int i = 0; i < 5; i++) read_chk(i);

        // ebreak at cycle 3
        run_prog(100, 3, -1, -1);
        read_chk(3);
        read_chk(0);

        // budget expiry with wrap-around
        run_prog(1000, -1, -1, -1);
        read_chk(0);
        read_chk(7);
        read_chk(15);

        // unlimited instance, 200 cycles
        sel = 1'b1;
        run_prog(200, -1, -1, -1);
        read_chk(0);
        read_chk(15);

        // reset in the middle of a run, then run again
        sel = 1'b0;
        run_prog(1000, -1, 10, -1);
        run_prog(3, -1, -1, -1);
        read_chk(0);
        read_chk(2);

        // start during RUN ignored; restarts from HALT
        run_prog(20, -1, -1, 7);
        read_chk(15);
        run_prog(2, -1, -1, -1);
        read_chk(1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/run_monitor.md
Name: run_monitor

Overview:
- Synthesizable run controller and execution tracer for the rv32i core; replaces the fixed 64-cycle simulation loop with a parametrised hardware equivalent.
- Sits beside Top: gates the core's run enable, counts retired cycles, stops on a halt condition and records the last TRACE_DEPTH {pc, instr, mem_out} triples in a circular buffer.
- Bench or debug logic reads the trace back after halt.

Parameters:
- PC_W, 16, width of pc.
- INSTR_W, 32, width of instr.
- DATA_W, 32, width of mem_out.
- MAX_CYCLES, 64, cycle budget; 0 means unlimited.
- TRACE_DEPTH, 16, trace entries; power of two, ≥2.
- HALT_INSTR, 32'h00100073, instruction word that halts the run (ebreak).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a run from IDLE or HALT.
- pc  in  PC_W  current core pc.
- instr  in  INSTR_W  current fetched instruction.
- instr_valid  in  1  high when instr holds a real ROM word; low means off the end of the program.
- mem_out  in  DATA_W  core data-memory output.
- core_en  out  1  run enable to the core.
- halted  out  1  high in HALT.
- halt_cause  out  2  00 none, 01 invalid instr, 10 HALT_INSTR, 11 cycle budget.
- cycle_count  out  32  cycles spent in RUN.
- trace_count  out  $clog2(TRACE_DEPTH)+1  valid trace entries, saturates at TRACE_DEPTH.
- rd_idx  in  $clog2(TRACE_DEPTH)  trace read index; 0 is the oldest valid entry.
- rd_pc  out  PC_W  registered trace read, pc field.
- rd_instr  out  INSTR_W  registered trace read, instr field.
- rd_data  out  DATA_W  registered trace read, data field.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; core_en=0, halted=0, halt_cause=00, cycle_count=0, trace_count=0.
  - Write pointer 0; rd_* = 0.
  - Trace RAM contents are not cleared.
- FSM IDLE → RUN → HALT.
- IDLE:
  - core_en=0.
  - start=1 → RUN next cycle; clears cycle_count, trace_count, write pointer and halt_cause.
- RUN:
  - core_en=1.
  - Each cycle with no halt condition: write {pc, instr, mem_out} at the write pointer, advance the pointer modulo TRACE_DEPTH, increment trace_count (saturating) and cycle_count.
- Halt checks, evaluated each RUN cycle in priority order:
  1. instr_valid=0 → cause 01.
  2. instr==HALT_INSTR → cause 10.
  3. MAX_CYCLES≠0 and cycle_count==MAX_CYCLES-1 → cause 11.
- On a halt condition:
  - Go to HALT next cycle. core_en drops in the same cycle as the halt condition (combinational on the condition) so the core does not advance.
  - A HALT_INSTR cycle is traced and counted; an invalid-instr cycle is neither traced nor counted; a budget cycle is traced and counted, so cycle_count ends at MAX_CYCLES.
- HALT:
  - core_en=0, halted=1; halt_cause, cycle_count and trace held.
  - start=1 → RUN with counters cleared, as from IDLE.
- start while in RUN is ignored.
- Trace readout:
  - Physical address = (wr_ptr − trace_count + rd_idx) mod TRACE_DEPTH.
  - rd_* are registered: one-cycle latency from rd_idx. Reads are valid in any state.
  - rd_idx ≥ trace_count returns stale RAM contents; this is legal, and the bench must not check it.
- Wrap-around: once more than TRACE_DEPTH cycles have been traced, the oldest entries are overwritten and trace_count stays at TRACE_DEPTH.
- cycle_count wraps at 2^32 when MAX_CYCLES=0 (unlimited).
- Reset mid-run: core_en falls asynchronously to 0; the block returns to IDLE.

Test Plan:
- Program of 5 valid instructions, then instr_valid=0; start pulse → halted=1, halt_cause=01, cycle_count=5, trace_count=5; rd_idx=0 returns pc=0, rd_idx=4 returns pc=16.
- instr=32'h00100073 at cycle 3 → halt_cause=10, cycle_count=4, trace_count=4; entry 3 rd_instr=32'h00100073; core_en=0 in the same cycle.
- MAX_CYCLES=64, endless valid loop → halt_cause=11 and cycle_count=64; TRACE_DEPTH=16 gives trace_count=16, and rd_idx=0 returns the cycle-48 entry.
- MAX_CYCLES=0, 200 valid cycles, then instr_valid=0 → cycle_count=200, halt_cause=01, rd_idx=15 returns the cycle-199 entry.
- rst_n pulled low at cycle 10 of a run → core_en=0 immediately, all outputs at reset values; a later start runs again from cycle_count=0.
- start pulsed during RUN is ignored, with counters uninterrupted; start in HALT restarts with halt_cause=00 and trace_count=0.
